// File: rtl/bus_arbiter_pkg.sv
// Shared state encoding and index helper for the round-robin bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURN
    } arb_state_t;

    // Modulo increment that does not rely on the master count being a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [IDX_W-1:0]       o_pick,
    output logic                   o_any_req
);

    logic [2*NUM_MASTERS-1:0] w_dbl;
    logic                     w_found;

    assign w_dbl     = {i_req, i_req};
    assign o_any_req = |i_req;

    // Scanning the doubled vector over [ptr, ptr+N) gives the wrap-around search.
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int j = 0; j < 2 * NUM_MASTERS; j++) begin
            if (!w_found && (j >= int'(i_ptr)) && (j < int'(i_ptr) + NUM_MASTERS) && w_dbl[j]) begin
                o_pick  = IDX_W'(j % NUM_MASTERS);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tri-state bus arbiter with a one-cycle turnaround between owners.
// Define BUS_ARBITER_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles (adds o_timeout).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 64
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_MASTERS-1:0]         i_req,
    output logic [NUM_MASTERS-1:0]         o_gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] o_owner,
    output logic                           o_bus_idle
`ifdef BUS_ARBITER_TIMEOUT_EN
    ,
    output logic                           o_timeout
`endif
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_owner;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic                   r_bus_idle;

    logic [NUM_MASTERS-1:0] w_req_eff;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_any_req;
    logic                   w_owner_req;
    logic                   w_timeout_hit;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [NUM_MASTERS-1:0] w_onehot;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0]      r_hold;
    logic [HOLD_W-1:0]      w_hold_next;
    logic [NUM_MASTERS-1:0] r_blocked;
    logic                   r_timeout;

    // A revoked master stays masked until it drops its request once.
    assign w_hold_next   = r_hold + HOLD_W'(1);
    assign w_timeout_hit = (w_hold_next == HOLD_W'(MAX_HOLD));
    assign w_req_eff     = i_req & ~r_blocked;
    assign o_timeout     = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign w_req_eff     = i_req;
`endif

    assign w_owner_req = i_req[r_owner];
    assign w_ptr_next  = IDX_W'(rr_next(int'(r_owner), NUM_MASTERS));
    assign w_onehot    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .i_req     (w_req_eff),
        .i_ptr     (r_ptr),
        .o_pick    (w_pick),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_bus_idle <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
            r_hold     <= '0;
            r_blocked  <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            r_timeout <= 1'b0;
            r_blocked <= r_blocked & i_req;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_gnt      <= w_onehot;
                        r_owner    <= w_pick;
                        r_bus_idle <= 1'b0;
                        r_state    <= ARB_GRANT;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        r_hold     <= '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    // A voluntary release takes precedence over a coinciding timeout.
                    if (!w_owner_req || w_timeout_hit) begin
                        r_gnt      <= '0;
                        r_bus_idle <= 1'b1;
                        r_ptr      <= w_ptr_next;
                        r_state    <= ARB_TURN;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        if (w_owner_req) begin
                            r_timeout          <= 1'b1;
                            r_blocked[r_owner] <= 1'b1;
                        end
                    end else begin
                        r_hold <= w_hold_next;
`endif
                    end
                end
                ARB_TURN: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_owner    = r_owner;
    assign o_bus_idle = r_bus_idle;

    a_params:  assert property (@(posedge clk) (NUM_MASTERS >= 2) && (MAX_HOLD >= 1));
    a_onehot:  assert property (@(posedge clk) disable iff (!n_rst) $onehot0(r_gnt));
    a_idle:    assert property (@(posedge clk) disable iff (!n_rst) r_bus_idle == (r_gnt == '0));

endmodule
